// File: rtl/split2d_stream_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// split2d_stream_if
// Bundles the input stream, the two output streams and the framing-error flag
// of split2d_stream. The producer/consumer side uses "master", the splitter
// uses "slave".
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
interface split2d_stream_if #(
  parameter int WIDTH = 16
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             s_last;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_last;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_last;
  logic             err;

  modport master (
    output s_valid, s_data, s_last, a_ready, b_ready,
    input  s_ready, a_valid, a_data, a_last, b_valid, b_data, b_last, err
  );

  modport slave (
    input  s_valid, s_data, s_last, a_ready, b_ready,
    output s_ready, a_valid, a_data, a_last, b_valid, b_data, b_last, err
  );
endinterface
`default_nettype wire

// File: rtl/split2d_stream.sv
`default_nettype none
// ----------------------------------------------------------------------------
// split2d_stream
// Splits one channel-major tensor of (A_CH+B_CH)*IN_H*IN_W words into an
// A portion (first A_CH channels) and a B portion (remaining B_CH channels).
// Each output owns a one-entry buffer so A and B back-pressure independently.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module split2d_stream #(
  parameter int A_CH      = 1,
  parameter int B_CH      = 1,
  parameter int IN_H      = 1,
  parameter int IN_W      = 1,
  parameter int WIDTH     = 16,
  parameter     PRECISION = "Q8.8"
) (
  input  logic              clk,
  input  logic              rst_n,
  split2d_stream_if.slave   bus
);

  localparam int A_N = A_CH * IN_H * IN_W;
  localparam int B_N = B_CH * IN_H * IN_W;
  localparam int TOT = A_N + B_N;
  localparam int CW  = (TOT > 1) ? $clog2(TOT) : 1;

  localparam logic [CW-1:0] c_a_last_idx = CW'(A_N - 1);
  localparam logic [CW-1:0] c_tot_last   = CW'(TOT - 1);
  localparam logic [CW-1:0] c_idx_one    = CW'(1);

  // Both portions must hold at least one word; the format tag must be present.
  if (A_N < 1 || B_N < 1 || PRECISION == 0) begin : g_bad_size
    $error("split2d_stream: A_N and B_N must be >= 1 and the precision tag set");
  end

  logic [CW-1:0]    r_idx;
  logic             r_err;
  logic             r_a_valid;
  logic [WIDTH-1:0] r_a_data;
  logic             r_a_last;
  logic             r_b_valid;
  logic [WIDTH-1:0] r_b_data;
  logic             r_b_last;

  logic             w_to_a;
  logic             w_idx_end;
  logic             w_s_ready;
  logic             w_acc;

  // Only the buffer of the current target decides whether a word can enter;
  // the other lane may be stalled without blocking this one.
  assign w_to_a    = (r_idx <= c_a_last_idx);
  assign w_idx_end = (r_idx == c_tot_last);
  assign w_s_ready = w_to_a ? (!r_a_valid || bus.a_ready)
                            : (!r_b_valid || bus.b_ready);
  assign w_acc     = bus.s_valid && w_s_ready;

  // Word index and sticky framing flag. An early s_last resyncs the index to
  // the start of a tensor; a missing s_last only flags the error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_err <= 1'b0;
    end else if (w_acc) begin
      if (w_idx_end || bus.s_last) begin
        r_idx <= '0;
      end else begin
        r_idx <= r_idx + c_idx_one;
      end
      if (bus.s_last != w_idx_end) begin
        r_err <= 1'b1;
      end
    end
  end

  // Output A buffer: a write wins over a same-cycle pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_valid <= 1'b0;
      r_a_data  <= '0;
      r_a_last  <= 1'b0;
    end else if (w_acc && w_to_a) begin
      r_a_valid <= 1'b1;
      r_a_data  <= bus.s_data;
      r_a_last  <= (r_idx == c_a_last_idx);
    end else if (bus.a_ready) begin
      r_a_valid <= 1'b0;
    end
  end

  // Output B buffer: a write wins over a same-cycle pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b_valid <= 1'b0;
      r_b_data  <= '0;
      r_b_last  <= 1'b0;
    end else if (w_acc && !w_to_a) begin
      r_b_valid <= 1'b1;
      r_b_data  <= bus.s_data;
      r_b_last  <= w_idx_end;
    end else if (bus.b_ready) begin
      r_b_valid <= 1'b0;
    end
  end

  assign bus.s_ready = w_s_ready;
  assign bus.a_valid = r_a_valid;
  assign bus.a_data  = r_a_data;
  assign bus.a_last  = r_a_last;
  assign bus.b_valid = r_b_valid;
  assign bus.b_data  = r_b_data;
  assign bus.b_last  = r_b_last;
  assign bus.err     = r_err;

endmodule
`default_nettype wire
